spi_buffer_tx: RTL and testbench

SPI initiator that sends a 1–4 byte buffer to the PET's SPI target interface. It generates `spi_sclk` and `spi_cs_n` from the system clock and shifts `tx[0]..tx[length-1]` out MSB-first. It is the counterpart of the target-side receive buffer, which collects incoming bytes into `rx[0..3]` according to `length`. Optionally, it also captures the target's return bytes.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sclk_div.sv | 44 ++++
 rtl/spi_buffer_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_buffer_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI buffer transmitter.
//   SPI_MAX_LENGTH : default buffer depth in bytes
//   spi_byte_t     : one data byte
//   spi_len_t      : transfer length field (bytes)
//   spi_tx_state_t : transmitter FSM states
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_MAX_LENGTH = 4;

  typedef logic [7:0] spi_byte_t;
  typedef logic [2:0] spi_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_tx_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// -----------------------------------------------------------------------------
// spi_sclk_div
// Half-period timer for the SPI transmitter. Counts DIV system clocks and
// raises tick for one cycle at the end of each half period.
// Ports:
//   sys_clk     in  : system clock (rising edge)
//   sys_reset_n in  : asynchronous active-low reset
//   clear       in  : restart the count (asserted when the FSM changes state)
//   tick        out : one-cycle pulse after DIV cycles in the current state
// -----------------------------------------------------------------------------
module spi_sclk_div #(
  parameter int DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // A state change coincides with tick except on leaving IDLE, so both
  // restart the count from zero; each state therefore lasts exactly DIV cycles.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_buffer_tx.sv
// -----------------------------------------------------------------------------
// spi_buffer_tx
// SPI mode-0 initiator that shifts a 1..MAX_LENGTH byte buffer out MSB-first,
// tx[0] first, generating spi_sclk and spi_cs_n from the system clock.
//
// Optional feature macro: SPI_BUFFER_TX_RX_CAPTURE_EN
//   defined   : spi_rx is sampled at each SCLK rising edge and assembled into
//               rx[byte] (bytes beyond length keep their previous value).
//   undefined : rx is held at zero and spi_rx is ignored.
//
// Ports:
//   sys_clk, sys_reset_n : clock, asynchronous active-low reset
//   start                : single-cycle transfer request (accepted in IDLE only)
//   length               : number of bytes, 1..MAX_LENGTH, sampled with start
//   tx                   : byte i at tx[8*i +: 8], sampled with start
//   busy                 : accepted start until end of the inter-transfer gap
//   done                 : one-cycle pulse as spi_cs_n rises
//   rx                   : captured return bytes, byte i at rx[8*i +: 8]
//   spi_sclk, spi_cs_n, spi_tx : SPI bus outputs, all straight from flops
//   spi_rx               : MISO
// -----------------------------------------------------------------------------
module spi_buffer_tx
  import spi_pkg::*;
#(
  parameter int SCLK_DIV   = 2,
  parameter int MAX_LENGTH = SPI_MAX_LENGTH
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset_n,
  input  logic                    start,
  input  logic [2:0]              length,
  input  logic [8*MAX_LENGTH-1:0] tx,
  output logic                    busy,
  output logic                    done,
  output logic [8*MAX_LENGTH-1:0] rx,
  output logic                    spi_sclk,
  output logic                    spi_cs_n,
  output logic                    spi_tx,
  input  logic                    spi_rx
);

  localparam int TOTAL = 8 * MAX_LENGTH;
  localparam int BIT_W = $clog2(TOTAL);

  spi_tx_state_t    state_q, state_d;
  logic [TOTAL-1:0] shift_q, shift_d;
  spi_len_t         len_q, len_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tick;
  logic             div_clear;
  logic             start_ok;
  logic             last_bit;
  logic [5:0]       n_bits;
  logic [BIT_W-1:0] last_idx;
  logic [TOTAL-1:0] load_vec;

  // Reorder the byte buffer so that the first bit on the wire (bit 7 of
  // tx[0]) sits at the MSB of the shift register.
  generate
    for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : g_load
      assign load_vec[TOTAL-1-8*gi -: 8] = tx[8*gi +: 8];
    end
  endgenerate

  assign start_ok = start && (length != 3'd0) && (int'(length) <= MAX_LENGTH);
  assign n_bits   = {len_q, 3'b000};
  assign last_idx = BIT_W'(n_bits - 6'd1);
  assign last_bit = (bit_q == last_idx);

  spi_sclk_div #(
    .DIV (SCLK_DIV)
  ) u_div (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .clear       (div_clear),
    .tick        (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    len_d   = len_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_SETUP;
          shift_d = load_vec;
          len_d   = length;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          mosi_d  = load_vec[TOTAL-1];
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          // After the final rising edge the falling edge leads straight into
          // HOLD, so the last bit stays on MOSI until chip select rises.
          if (last_bit) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q << 1;
            mosi_d  = shift_q[TOTAL-2];
          end
        end
      end
      ST_LOW: begin
        if (tick) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign div_clear = (state_d != state_q);

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_tx   = mosi_q;

`ifdef SPI_BUFFER_TX_RX_CAPTURE_EN
  // The system-clock edge that raises spi_sclk is the target's MOSI sample
  // point; MISO is sampled on the same edge, at bit index bit_q.
  logic       sclk_rise;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] rx_next;

  assign sclk_rise = tick && ((state_q == ST_SETUP) || (state_q == ST_LOW));
  assign rx_next   = {rx_byte_q[6:0], spi_rx};

  always_comb begin
    rx_byte_d = rx_byte_q;
    if (sclk_rise) begin
      rx_byte_d = rx_next;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rx_byte_q <= '0;
    end else begin
      rx_byte_q <= rx_byte_d;
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : g_rx
      logic [7:0] rx_q, rx_d;
      logic       wr_en;

      // Write on the 8th bit of byte gi, using the freshly shifted value.
      assign wr_en = sclk_rise && (bit_q[2:0] == 3'd7) && (int'(bit_q >> 3) == gi);

      always_comb begin
        rx_d = rx_q;
        if (wr_en) begin
          rx_d = rx_next;
        end
      end

      always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
          rx_q <= '0;
        end else begin
          rx_q <= rx_d;
        end
      end

      assign rx[8*gi +: 8] = rx_q;
    end
  endgenerate
`else
  logic unused_spi_rx;
  assign unused_spi_rx = spi_rx;
  assign rx            = '0;
`endif

endmodule

// File: tb/tb_spi_buffer_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_buffer_tx
// Directed bench for spi_buffer_tx (SCLK_DIV=2, MAX_LENGTH=4). A target model
// samples MOSI on SCLK rising edges and drives MISO on falling edges; expected
// MOSI bytes are queued when a transfer starts and compared as they arrive.
// Honours SPI_BUFFER_TX_RX_CAPTURE_EN for the rx expectations.
// -----------------------------------------------------------------------------
module tb_spi_buffer_tx;

  localparam int D    = 2;
  localparam int MAXL = 4;

  logic              sys_clk = 1'b0;
  logic              sys_reset_n;
  logic              start;
  logic [2:0]        length;
  logic [8*MAXL-1:0] tx;
  logic              busy;
  logic              done;
  logic [8*MAXL-1:0] rx;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_tx;
  logic              spi_rx = 1'b0;

  spi_buffer_tx #(
    .SCLK_DIV   (D),
    .MAX_LENGTH (MAXL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .start       (start),
    .length      (length),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .rx          (rx),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_tx      (spi_tx),
    .spi_rx      (spi_rx)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // scoreboard of expected MOSI bytes
  logic [7:0] exp_q[$];
  logic [31:0] ret_val = 32'h0;

  // monitor state (written only by the monitor)
  int rises = 0, dones = 0, activity = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  int mon_bits = 0;
  logic [7:0]  mon_byte = 8'h0;
  logic [31:0] tgt_sh = 32'h0;
  logic cs_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;

  // snapshots taken by the stimulus block
  int r0 = 0, d0 = 0, a0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // target model and bus monitor, sampling mid-cycle
  always @(negedge sys_clk) begin
    logic [7:0] e;
    if (cs_prev && !spi_cs_n) begin
      cs_fall_cyc = cyc;
      mon_bits    = 0;
      tgt_sh      = ret_val;
      spi_rx      = tgt_sh[31];
    end
    if (!cs_prev && spi_cs_n) cs_rise_cyc = cyc;
    if (!busy_prev && busy) busy_rise_cyc = cyc;
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    if (!sclk_prev && spi_sclk && !spi_cs_n) begin
      rises++;
      mon_byte = {mon_byte[6:0], spi_tx};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        e = 8'hxx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check("mosi_byte", {24'h0, mon_byte}, {24'h0, e});
        $display("byte: mosi=%h expected=%h", mon_byte, e);
      end
    end
    if (sclk_prev && !spi_sclk && !spi_cs_n) begin
      tgt_sh = tgt_sh << 1;
      spi_rx = tgt_sh[31];
    end
    if (done) dones++;
    if (busy || !spi_cs_n || spi_sclk || done) activity++;
    cs_prev   = spi_cs_n;
    sclk_prev = spi_sclk;
    busy_prev = busy;
  end

  task automatic pulse_start(input int len, input logic [31:0] txv);
    @(negedge sys_clk);
    length = 3'(len);
    tx     = txv;
    start  = 1'b1;
    @(negedge sys_clk);
    start  = 1'b0;
  endtask

  task automatic begin_xfer(input int len, input logic [31:0] txv, input logic [31:0] retv);
    r0 = rises;
    d0 = dones;
    ret_val = retv;
    for (int i = 0; i < len; i++) exp_q.push_back(txv[8*i +: 8]);
    pulse_start(len, txv);
    check("busy_after_start", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic end_xfer(input int len);
    wait_idle(2000);
    check("sclk_rises", rises - r0, 8 * len);
    check("done_pulses", dones - d0, 1);
    check("cs_low_cycles", cs_rise_cyc - cs_fall_cyc, 16 * len * D + D);
    check("busy_cycles", busy_fall_cyc - busy_rise_cyc, 16 * len * D + 2 * D);
    check("busy_vs_cs_start", busy_rise_cyc, cs_fall_cyc);
    check("sb_leftover", exp_q.size(), 0);
    $display("xfer: len=%0d rises=%0d dones=%0d cs_low=%0d busy=%0d",
             len, rises - r0, dones - d0, cs_rise_cyc - cs_fall_cyc,
             busy_fall_cyc - busy_rise_cyc);
  endtask

  initial begin
    sys_reset_n = 1'b0;
    start       = 1'b0;
    length      = 3'd0;
    tx          = '0;

    // reset values
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("rst_sclk", {31'h0, spi_sclk}, 32'h0);
    check("rst_mosi", {31'h0, spi_tx}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_rx", rx, 32'h0);
    $display("reset: cs_n=%b sclk=%b mosi=%b busy=%b done=%b rx=%h",
             spi_cs_n, spi_sclk, spi_tx, busy, done, rx);
    sys_reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // four-byte transfer
    begin_xfer(4, 32'h04030201, 32'h11223344);
    end_xfer(4);
`ifdef SPI_BUFFER_TX_RX_CAPTURE_EN
    check("rx_len4", rx, 32'h44332211);
`else
    check("rx_len4", rx, 32'h0);
`endif

    // illegal lengths are ignored
    a0 = activity;
    pulse_start(0, 32'hFFFFFFFF);
    repeat (200) @(negedge sys_clk);
    check("len0_idle", activity - a0, 0);
    $display("ignore: len=0 activity=%0d", activity - a0);
    a0 = activity;
    pulse_start(5, 32'hFFFFFFFF);
    repeat (200) @(negedge sys_clk);
    check("len5_idle", activity - a0, 0);
    $display("ignore: len=5 activity=%0d", activity - a0);

    // start while busy is ignored, original bytes are sent
    begin_xfer(4, 32'h78563412, 32'h11223344);
    repeat (9) @(negedge sys_clk);
    tx     = 32'hEEEEEEEE;
    length = 3'd1;
    start  = 1'b1;
    @(negedge sys_clk);
    start  = 1'b0;
    end_xfer(4);

    // two-byte transfer with return bytes C3, 3C
    begin_xfer(2, 32'h0000BEEF, 32'hC33C0000);
    end_xfer(2);
`ifdef SPI_BUFFER_TX_RX_CAPTURE_EN
    check("rx_len2", rx, 32'h44333CC3);
`else
    check("rx_len2", rx, 32'h0);
`endif

    // single byte A5
    begin_xfer(1, 32'h000000A5, 32'h5A000000);
    end_xfer(1);
`ifdef SPI_BUFFER_TX_RX_CAPTURE_EN
    check("rx_len1", rx, 32'h44333C5A);
`else
    check("rx_len1", rx, 32'h0);
`endif

    // asynchronous reset at bit 12
    begin_xfer(4, 32'hDDCCBBAA, 32'h0);
    begin
      int k = 0;
      while ((rises - r0) < 13 && k < 300) begin
        @(negedge sys_clk);
        k++;
      end
    end
    check("reach_bit12", rises - r0, 13);
    #1 sys_reset_n = 1'b0;
    #1;
    check("arst_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("arst_sclk", {31'h0, spi_sclk}, 32'h0);
    check("arst_mosi", {31'h0, spi_tx}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_rx", rx, 32'h0);
    $display("async reset: cs_n=%b sclk=%b mosi=%b busy=%b", spi_cs_n, spi_sclk, spi_tx, busy);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    exp_q.delete();
    repeat (20) @(negedge sys_clk);
    check("arst_no_done", dones - d0, 0);

    // transfer after reset
    begin_xfer(2, 32'h00009A5B, 32'h0FF00000);
    end_xfer(2);
`ifdef SPI_BUFFER_TX_RX_CAPTURE_EN
    check("rx_after_rst", rx, 32'h0000F00F);
`else
    check("rx_after_rst", rx, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
